impulse_seq_ctrl: RTL and testbench
===================================

IMPULSE_SEQ_CTRL -- requirements
Module: impulse_seq_ctrl

Interface
REQ-001 The block SHALL have parameter REQ_TIMEOUT, default 1024: clocks to wait for DATA_WR after REQ_COMM before re-requesting.
REQ-002 The block SHALL have parameter FREQ_W, default 48: width of the frequency path.
REQ-003 CLK  in  1  single clock; every register SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 TIME  in  64  system time in clocks.
REQ-006 ABORT  in  1  abort the current command.
REQ-007 DATA_WR  in  1  one-cycle strobe; the command field inputs are valid on this cycle.
REQ-008 FREQ  in  48  start frequency code.
REQ-009 FREQ_STEP  in  48  frequency increment.
REQ-010 FREQ_RATE  in  32  clocks between intra-pulse steps.
REQ-011 TIME_START  in  64  start time.
REQ-012 N_impulse  in  16  pulse count.
REQ-013 TYPE_impulse  in  2  stepping mode.
REQ-014 Interval_Ti  in  32  pulse width, in clocks.
REQ-015 Interval_Tp  in  32  pulse period, in clocks.
REQ-016 Tblank1  in  32  lead blanking, in clocks.
REQ-017 Tblank2  in  32  trail blanking, in clocks.
REQ-018 REQ_COMM  out  1  one-cycle request for the next command.
REQ-019 IMP  out  1  pulse active.
REQ-020 BLANK  out  1  blanking window.
REQ-021 FREQ_OUT  out  48  current frequency code.
REQ-022 FREQ_LOAD  out  1  one-cycle strobe, high on each FREQ_OUT update.
REQ-023 BUSY  out  1  high in every state except IDLE and REQ/WAIT_CMD.
REQ-024 IMP_CNT  out  16  number of pulses completed.
REQ-025 ERR_LATE  out  1  one-cycle flag: command expired before start.
REQ-026 ERR_CFG  out  1  one-cycle flag: invalid command.

Function
REQ-027 The FSM states SHALL be: IDLE, REQ, WAIT_CMD, ARMED, BLANK1, PULSE, GAP, BLANK2.
REQ-028 IDLE SHALL last 1 cycle and then go to REQ.
REQ-029 REQ SHALL drive REQ_COMM=1 for exactly 1 cycle and then go to WAIT_CMD.
REQ-030 WAIT_CMD, on DATA_WR=1, SHALL latch all field inputs and go to ARMED on the next cycle.
REQ-031 WAIT_CMD, after REQ_TIMEOUT cycles without DATA_WR, SHALL return to REQ.
REQ-032 DATA_WR in any state other than WAIT_CMD SHALL be ignored.
REQ-033 On the first ARMED cycle, a latched command SHALL be discarded, with ERR_CFG pulsed and a return to REQ, when any of these holds: TIME_START=64'hFFFF_FFFF_FFFF_FFFF (empty slot); N_impulse=0; Interval_Ti=0; Interval_Ti>=Interval_Tp.
REQ-034 On the first ARMED cycle, if the command passes REQ-033 and TIME>TIME_START, the block SHALL pulse ERR_LATE, discard the command and go to REQ.
REQ-035 While in ARMED, on the first cycle with TIME>=TIME_START, the block SHALL go to BLANK1; BLANK SHALL rise on the next cycle.
REQ-036 BLANK1 SHALL hold BLANK=1 for Tblank1 cycles; if Tblank1=0 the state SHALL be skipped and PULSE entered directly.
REQ-037 On PULSE entry, the block SHALL set FREQ_OUT to its value for that pulse and pulse FREQ_LOAD on the same cycle IMP rises.
REQ-038 PULSE SHALL hold IMP=1 for Interval_Ti cycles.
REQ-039 GAP SHALL hold IMP=0 for Interval_Tp-Interval_Ti cycles.
REQ-040 IMP rising edges SHALL be exactly Interval_Tp cycles apart.
REQ-041 IMP_CNT SHALL increment on each PULSE exit.
REQ-042 After pulse N_impulse completes its PULSE phase, the block SHALL go to BLANK2 immediately, with no trailing GAP.
REQ-043 BLANK2 SHALL hold BLANK=1 for Tblank2 cycles (0 cycles skips the state) and then go to REQ.
REQ-044 TYPE_impulse=0: FREQ_OUT SHALL equal FREQ for every pulse.
REQ-045 TYPE_impulse=1: FREQ_OUT SHALL be set to FREQ at each pulse start and SHALL increase by FREQ_STEP every FREQ_RATE cycles within PULSE, with a FREQ_LOAD pulse on each increment; FREQ_RATE=0 SHALL mean no stepping.
REQ-046 TYPE_impulse=2: pulse k (k counted from 0) SHALL use FREQ_OUT = FREQ + k*FREQ_STEP, computed by accumulation with no multiplier.
REQ-047 TYPE_impulse=3 SHALL behave as TYPE_impulse=0.
REQ-048 All frequency arithmetic SHALL be unsigned modulo 2^48, with wrap-around and no saturation.
REQ-049 Duration counters SHALL be 32-bit and count down; a load value of 1 SHALL give exactly 1 cycle.
REQ-050 ABORT=1 in any state SHALL, on the next cycle, force IMP=0 and BLANK=0 and put the FSM in IDLE; FREQ_OUT and IMP_CNT SHALL hold their values.
REQ-051 ABORT SHALL take priority over DATA_WR and over timer expiry.
REQ-052 TIME jumps (system time reset) while in ARMED SHALL be re-evaluated by the >= compare on each cycle and SHALL NOT raise ERR_LATE.
REQ-053 TIME jumps during BLANK1/PULSE/GAP/BLANK2 SHALL have no effect, since phase timing is by local counters only.
REQ-054 IMP_CNT SHALL clear on each WAIT_CMD->ARMED transition.

Reset
REQ-055 When rst_n=0 at a CLK edge: state SHALL be IDLE; REQ_COMM, IMP, BLANK, FREQ_LOAD, BUSY, ERR_LATE, ERR_CFG SHALL be 0; FREQ_OUT=0; IMP_CNT=0; all latched fields and counters SHALL be 0.
REQ-056 Reset asserted mid-pulse SHALL drop IMP on the first clock edge with rst_n=0.
REQ-057 The first REQ_COMM after reset release SHALL occur on the 2nd cycle with rst_n=1.

Verification
REQ-058 Basic run: TIME=1000, command TIME_START=1100, N=3, Ti=4, Tp=10, Tblank1=5, Tblank2=2, TYPE=0, FREQ=100 -> BLANK high 5 cycles starting 1 cycle after TIME=1100; IMP rises at offsets +6,+16,+26, each 4 cycles wide; BLANK high 2 cycles after the third pulse; IMP_CNT=3; FREQ_OUT=100; then REQ_COMM.
REQ-059 Stepping: TYPE=2, FREQ=48'hFFFF_FFFF_FFFE, FREQ_STEP=1, N=3 -> FREQ_OUT per pulse = FFFF_FFFF_FFFE, FFFF_FFFF_FFFF, 0 (wrap); FREQ_LOAD pulses 3 times.
REQ-060 Late and invalid: TIME_START=TIME-1 -> ERR_LATE pulse, IMP never rises, REQ_COMM reissued; Ti=10, Tp=10 -> ERR_CFG pulse, no IMP; TIME_START=all-ones -> ERR_CFG pulse.
REQ-061 Timeout: no DATA_WR after REQ_COMM -> REQ_COMM repeats every REQ_TIMEOUT+1 cycles (1025 at default).
REQ-062 Abort: ABORT pulsed on the 2nd cycle of pulse 2 -> IMP=0 and BLANK=0 on the next cycle, IMP_CNT=1, then IDLE followed by REQ_COMM; a DATA_WR issued during PULSE is ignored.

Source files
------------

// File: rtl/impulse_seq_ctrl.sv
// Pulse sequencer: fetches a timed command, then plays blank / pulse train / blank with
// per-pulse frequency programming, requesting the next command when done or on error.
module impulse_seq_ctrl #(
  parameter int unsigned REQ_TIMEOUT = 1024,
  parameter int unsigned FREQ_W      = 48
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [63:0]       TIME,
  input  logic              ABORT,
  input  logic              DATA_WR,
  input  logic [FREQ_W-1:0] FREQ,
  input  logic [FREQ_W-1:0] FREQ_STEP,
  input  logic [31:0]       FREQ_RATE,
  input  logic [63:0]       TIME_START,
  input  logic [15:0]       N_impulse,
  input  logic [1:0]        TYPE_impulse,
  input  logic [31:0]       Interval_Ti,
  input  logic [31:0]       Interval_Tp,
  input  logic [31:0]       Tblank1,
  input  logic [31:0]       Tblank2,
  output logic              REQ_COMM,
  output logic              IMP,
  output logic              BLANK,
  output logic [FREQ_W-1:0] FREQ_OUT,
  output logic              FREQ_LOAD,
  output logic              BUSY,
  output logic [15:0]       IMP_CNT,
  output logic              ERR_LATE,
  output logic              ERR_CFG
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StWaitCmd = 3'd2;
  localparam logic [2:0] StArmed   = 3'd3;
  localparam logic [2:0] StBlank1  = 3'd4;
  localparam logic [2:0] StPulse   = 3'd5;
  localparam logic [2:0] StGap     = 3'd6;
  localparam logic [2:0] StBlank2  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       rcnt_q, rcnt_d;
  logic              first_q, first_d;
  logic [FREQ_W-1:0] freq_out_q, freq_out_d;
  logic [FREQ_W-1:0] base_q, base_d;
  logic [15:0]       imp_cnt_q, imp_cnt_d;
  logic              freq_load_q, freq_load_d;
  logic              err_late_q, err_late_d;
  logic              err_cfg_q, err_cfg_d;
  logic [FREQ_W-1:0] step_q, step_d;
  logic [31:0]       rate_q, rate_d;
  logic [63:0]       tstart_q, tstart_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       ti_q, ti_d, tp_q, tp_d, tb1_q, tb1_d, tb2_q, tb2_d;
  logic              pulse_start;
  logic              cfg_bad;

  assign cfg_bad = (tstart_q == '1) || (n_q == 16'd0) || (ti_q == 32'd0) || (ti_q >= tp_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    first_d     = 1'b0;
    freq_out_d  = freq_out_q;
    base_d      = base_q;
    imp_cnt_d   = imp_cnt_q;
    freq_load_d = 1'b0;
    err_late_d  = 1'b0;
    err_cfg_d   = 1'b0;
    step_d      = step_q;
    rate_d      = rate_q;
    tstart_d    = tstart_q;
    n_d         = n_q;
    type_d      = type_q;
    ti_d        = ti_q;
    tp_d        = tp_q;
    tb1_d       = tb1_q;
    tb2_d       = tb2_q;
    pulse_start = 1'b0;
    if (ABORT) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          state_d = StWaitCmd;
          cnt_d   = 32'(REQ_TIMEOUT);
        end
        StWaitCmd: begin
          if (DATA_WR) begin
            base_d    = FREQ;
            step_d    = FREQ_STEP;
            rate_d    = FREQ_RATE;
            tstart_d  = TIME_START;
            n_d       = N_impulse;
            type_d    = TYPE_impulse;
            ti_d      = Interval_Ti;
            tp_d      = Interval_Tp;
            tb1_d     = Tblank1;
            tb2_d     = Tblank2;
            imp_cnt_d = 16'd0;
            first_d   = 1'b1;
            state_d   = StArmed;
          end else if (cnt_q <= 32'd1) begin
            state_d = StReq;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        StArmed: begin
          // Late check only on the first cycle so later TIME jumps just re-compare.
          if (first_q && cfg_bad) begin
            err_cfg_d = 1'b1;
            state_d   = StReq;
          end else if (first_q && (TIME > tstart_q)) begin
            err_late_d = 1'b1;
            state_d    = StReq;
          end else if (TIME >= tstart_q) begin
            if (tb1_q != 32'd0) begin
              state_d = StBlank1;
              cnt_d   = tb1_q;
            end else begin
              pulse_start = 1'b1;
            end
          end
        end
        StBlank1, StGap: begin
          if (cnt_q == 32'd1) pulse_start = 1'b1;
          else cnt_d = cnt_q - 32'd1;
        end
        StPulse: begin
          if (cnt_q == 32'd1) begin
            imp_cnt_d = imp_cnt_q + 16'd1;
            if (imp_cnt_q + 16'd1 == n_q) begin
              if (tb2_q != 32'd0) begin
                state_d = StBlank2;
                cnt_d   = tb2_q;
              end else begin
                state_d = StReq;
              end
            end else begin
              state_d = StGap;
              cnt_d   = tp_q - ti_q;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
            if (type_q == 2'd1 && rate_q != 32'd0) begin
              if (rcnt_q == 32'd1) begin
                freq_out_d  = freq_out_q + step_q;
                freq_load_d = 1'b1;
                rcnt_d      = rate_q;
              end else begin
                rcnt_d = rcnt_q - 32'd1;
              end
            end
          end
        end
        StBlank2: begin
          if (cnt_q == 32'd1) state_d = StReq;
          else cnt_d = cnt_q - 32'd1;
        end
        default: state_d = StIdle;
      endcase
    end
    if (pulse_start) begin
      state_d     = StPulse;
      cnt_d       = ti_q;
      rcnt_d      = rate_q;
      freq_out_d  = base_q;
      freq_load_d = 1'b1;
      // Sweep mode: base accumulates one step per pulse, no multiplier needed.
      if (type_q == 2'd2) base_d = base_q + step_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      first_q     <= 1'b0;
      freq_out_q  <= '0;
      base_q      <= '0;
      imp_cnt_q   <= '0;
      freq_load_q <= 1'b0;
      err_late_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
      step_q      <= '0;
      rate_q      <= '0;
      tstart_q    <= '0;
      n_q         <= '0;
      type_q      <= '0;
      ti_q        <= '0;
      tp_q        <= '0;
      tb1_q       <= '0;
      tb2_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      first_q     <= first_d;
      freq_out_q  <= freq_out_d;
      base_q      <= base_d;
      imp_cnt_q   <= imp_cnt_d;
      freq_load_q <= freq_load_d;
      err_late_q  <= err_late_d;
      err_cfg_q   <= err_cfg_d;
      step_q      <= step_d;
      rate_q      <= rate_d;
      tstart_q    <= tstart_d;
      n_q         <= n_d;
      type_q      <= type_d;
      ti_q        <= ti_d;
      tp_q        <= tp_d;
      tb1_q       <= tb1_d;
      tb2_q       <= tb2_d;
    end
  end

  assign REQ_COMM  = (state_q == StReq);
  assign IMP       = (state_q == StPulse);
  assign BLANK     = (state_q == StBlank1) || (state_q == StBlank2);
  assign BUSY      = (state_q != StIdle) && (state_q != StReq) && (state_q != StWaitCmd);
  assign FREQ_OUT  = freq_out_q;
  assign FREQ_LOAD = freq_load_q;
  assign IMP_CNT   = imp_cnt_q;
  assign ERR_LATE  = err_late_q;
  assign ERR_CFG   = err_cfg_q;

endmodule

// File: tb/tb_impulse_seq_ctrl.sv
// Bench for impulse_seq_ctrl: directed scenarios plus random commands checked against an
// expected waveform built from the pulse-train rules.
module tb_impulse_seq_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] TIME;
  logic        ABORT, DATA_WR;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic        REQ_COMM, IMP, BLANK, FREQ_LOAD, BUSY, ERR_LATE, ERR_CFG;
  logic [47:0] FREQ_OUT;
  logic [15:0] IMP_CNT;

  impulse_seq_ctrl dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .ABORT(ABORT), .DATA_WR(DATA_WR),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
    .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .REQ_COMM(REQ_COMM), .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
    .FREQ_LOAD(FREQ_LOAD), .BUSY(BUSY), .IMP_CNT(IMP_CNT), .ERR_LATE(ERR_LATE),
    .ERR_CFG(ERR_CFG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] freq, stp;
    logic [31:0] rate;
    logic [63:0] ts;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti, tp, tb1, tb2;
  } cmd_t;

  typedef struct {
    logic        imp, blank, load, req, fchk;
    logic [47:0] f;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    TIME = TIME + 64'd1;
  endtask

  function automatic cmd_t mk(input logic [47:0] f, input logic [47:0] s, input logic [31:0] r,
                              input logic [63:0] ts, input logic [15:0] n, input logic [1:0] t,
                              input logic [31:0] ti, input logic [31:0] tp,
                              input logic [31:0] b1, input logic [31:0] b2);
    cmd_t c;
    c.freq = f; c.stp = s; c.rate = r; c.ts = ts; c.n = n; c.typ = t;
    c.ti = ti; c.tp = tp; c.tb1 = b1; c.tb2 = b2;
    return c;
  endfunction

  function automatic ev_t ev(input logic i, input logic b, input logic l, input logic rq,
                             input logic fc, input logic [47:0] f);
    ev_t e;
    e.imp = i; e.blank = b; e.load = l; e.req = rq; e.fchk = fc; e.f = f;
    return e;
  endfunction

  // Expected per-cycle outputs from the first cycle after TIME reaches TIME_START.
  function automatic void build(input cmd_t c);
    logic [47:0] fk, fs, last;
    logic        stepping, ld;
    stepping = (c.typ == 2'd1) && (c.rate != 32'd0);
    last = '0;
    exp_q.delete();
    for (int i = 0; i < int'(c.tb1); i++) exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    for (int k = 0; k < int'(c.n); k++) begin
      fk = (c.typ == 2'd2) ? c.freq + 48'(k) * c.stp : c.freq;
      for (int i = 0; i < int'(c.ti); i++) begin
        fs = stepping ? fk + 48'(i / int'(c.rate)) * c.stp : fk;
        ld = (i == 0) || (stepping && (i % int'(c.rate) == 0));
        exp_q.push_back(ev(1'b1, 1'b0, ld, 1'b0, 1'b1, fs));
        last = fs;
      end
      if (k < int'(c.n) - 1)
        for (int i = 0; i < int'(c.tp - c.ti); i++)
          exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last));
    end
    for (int i = 0; i < int'(c.tb2); i++) exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, last));
    exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, last));
  endfunction

  task automatic wait_req();
    int g = 0;
    while (REQ_COMM !== 1'b1 && g < 1100) begin
      step();
      g++;
    end
    chk1("req_wait", REQ_COMM, 1'b1);
  endtask

  // rel=1: c.ts is an offset added to TIME on the DATA_WR cycle.
  task automatic send(input cmd_t c, input logic rel);
    wait_req();
    step();
    FREQ = c.freq; FREQ_STEP = c.stp; FREQ_RATE = c.rate; N_impulse = c.n;
    TYPE_impulse = c.typ; Interval_Ti = c.ti; Interval_Tp = c.tp;
    Tblank1 = c.tb1; Tblank2 = c.tb2;
    TIME_START = rel ? TIME + c.ts : c.ts;
    DATA_WR = 1'b1;
  endtask

  task automatic run_cmd(input cmd_t c, input logic rel);
    int g = 0;
    send(c, rel);
    build(c);
    step();
    DATA_WR = 1'b0;
    while (TIME <= TIME_START && g < 3000) begin
      chk1("armed_imp", IMP, 1'b0);
      chk1("armed_busy", BUSY, 1'b1);
      step();
      g++;
    end
    foreach (exp_q[j]) begin
      chk1("imp", IMP, exp_q[j].imp);
      chk1("blank", BLANK, exp_q[j].blank);
      chk1("freq_load", FREQ_LOAD, exp_q[j].load);
      chk1("req_comm", REQ_COMM, exp_q[j].req);
      if (exp_q[j].fchk) chkw("freq_out", 64'(FREQ_OUT), 64'(exp_q[j].f));
      if (j < exp_q.size() - 1) step();
    end
    chkw("imp_cnt", 64'(IMP_CNT), 64'(c.n));
    chk1("busy_end", BUSY, 1'b0);
  endtask

  task automatic expect_err(input logic late);
    step();
    DATA_WR = 1'b0;
    chk1("err_armed_busy", BUSY, 1'b1);
    step();
    chk1("err_late", ERR_LATE, late);
    chk1("err_cfg", ERR_CFG, !late);
    chk1("err_req", REQ_COMM, 1'b1);
    chk1("err_imp", IMP, 1'b0);
  endtask

  initial begin
    cmd_t        c;
    logic [63:0] rv, rv2;
    int          n;

    rst_n = 1'b0; TIME = '0; ABORT = 1'b0; DATA_WR = 1'b0; FREQ = '0; FREQ_STEP = '0;
    FREQ_RATE = '0; TIME_START = '0; N_impulse = '0; TYPE_impulse = '0; Interval_Ti = '0;
    Interval_Tp = '0; Tblank1 = '0; Tblank2 = '0;
    repeat (3) step();
    chk1("rst_req", REQ_COMM, 1'b0);
    chk1("rst_imp", IMP, 1'b0);
    chk1("rst_blank", BLANK, 1'b0);
    chk1("rst_load", FREQ_LOAD, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_late", ERR_LATE, 1'b0);
    chk1("rst_cfg", ERR_CFG, 1'b0);
    chkw("rst_freq", 64'(FREQ_OUT), 64'd0);
    chkw("rst_cnt", 64'(IMP_CNT), 64'd0);
    rst_n = 1'b1;
    chk1("rel_cyc1_req", REQ_COMM, 1'b0);
    step();
    chk1("rel_cyc2_req", REQ_COMM, 1'b1);

    // Basic run with absolute start time
    TIME = 64'd990;
    run_cmd(mk(48'd100, 48'd0, 32'd0, 64'd1100, 16'd3, 2'd0, 32'd4, 32'd10, 32'd5, 32'd2), 1'b0);

    // Per-pulse sweep wrapping through zero
    run_cmd(mk(48'hFFFF_FFFF_FFFE, 48'd1, 32'd0, 64'd3, 16'd3, 2'd2, 32'd2, 32'd4, 32'd1, 32'd1),
            1'b1);

    // Late, Ti==Tp, empty slot
    send(mk(48'd5, 48'd0, 32'd0, '1, 16'd1, 2'd0, 32'd2, 32'd4, 32'd0, 32'd0), 1'b1);
    expect_err(1'b1);
    send(mk(48'd5, 48'd0, 32'd0, 64'd3, 16'd1, 2'd0, 32'd10, 32'd10, 32'd0, 32'd0), 1'b1);
    expect_err(1'b0);
    send(mk(48'd5, 48'd0, 32'd0, '1, 16'd1, 2'd0, 32'd2, 32'd4, 32'd0, 32'd0), 1'b0);
    expect_err(1'b0);

    // Request timeout period
    wait_req();
    n = 0;
    do begin
      step();
      n++;
    end while (REQ_COMM !== 1'b1 && n < 2000);
    chkw("timeout_period", 64'(n), 64'd1025);

    // Abort on the 2nd cycle of pulse 2; a DATA_WR during pulse 1 must be ignored
    send(mk(48'h123, 48'd0, 32'd0, 64'd2, 16'd3, 2'd0, 32'd4, 32'd10, 32'd0, 32'd2), 1'b1);
    step();
    DATA_WR = 1'b0;
    n = 0;
    while (IMP !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk1("abort_p1_rise", IMP, 1'b1);
    DATA_WR = 1'b1; N_impulse = 16'd1; FREQ = 48'h999;
    step();
    DATA_WR = 1'b0;
    repeat (9) step();
    chk1("abort_p2_rise", IMP, 1'b1);
    chk1("abort_p2_load", FREQ_LOAD, 1'b1);
    chkw("abort_p2_freq", 64'(FREQ_OUT), 64'h123);
    step();
    chk1("abort_p2_cyc2", IMP, 1'b1);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk1("abort_imp", IMP, 1'b0);
    chk1("abort_blank", BLANK, 1'b0);
    chk1("abort_busy", BUSY, 1'b0);
    chkw("abort_cnt", 64'(IMP_CNT), 64'd1);
    chkw("abort_freq", 64'(FREQ_OUT), 64'h123);
    chk1("abort_idle_req", REQ_COMM, 1'b0);
    step();
    chk1("abort_then_req", REQ_COMM, 1'b1);

    // TIME jumps past the start while armed: start, no late flag
    send(mk(48'd7, 48'd0, 32'd0, 64'd50, 16'd1, 2'd0, 32'd2, 32'd3, 32'd2, 32'd1), 1'b1);
    step();
    DATA_WR = 1'b0;
    step();
    TIME = TIME_START + 64'd100;
    step();
    chk1("jump_late", ERR_LATE, 1'b0);
    chk1("jump_blank", BLANK, 1'b1);
    chk1("jump_busy", BUSY, 1'b1);

    for (int r = 0; r < 12; r++) begin
      rv  = {$urandom(), $urandom()};
      rv2 = {$urandom(), $urandom()};
      c = mk(rv[47:0], rv2[47:0], 32'($urandom_range(0, 3)), 64'($urandom_range(1, 7)),
             16'($urandom_range(1, 4)), 2'($urandom_range(0, 3)), 32'($urandom_range(1, 6)),
             32'd0, 32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)));
      c.tp = c.ti + 32'($urandom_range(1, 6));
      run_cmd(c, 1'b1);
    end

    // Reset in the middle of a pulse
    send(mk(48'h55, 48'd0, 32'd0, 64'd2, 16'd2, 2'd0, 32'd5, 32'd8, 32'd0, 32'd0), 1'b1);
    step();
    DATA_WR = 1'b0;
    n = 0;
    while (IMP !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk1("mid_rise", IMP, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    chk1("mid_rst_imp", IMP, 1'b0);
    chk1("mid_rst_busy", BUSY, 1'b0);
    chkw("mid_rst_freq", 64'(FREQ_OUT), 64'd0);
    chkw("mid_rst_cnt", 64'(IMP_CNT), 64'd0);
    rst_n = 1'b1;
    chk1("mid_rel_cyc1", REQ_COMM, 1'b0);
    step();
    chk1("mid_rel_cyc2", REQ_COMM, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
